// File: rtl/ysyx_220053_ifu.sv
// Instruction fetch unit. It issues one fetch at a time to instruction memory,
// buffers returned words with their PCs in a 2-entry FIFO toward the decoder,
// and flushes or drops in-flight work when a redirect arrives.
module ysyx_220053_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    input  logic        halt,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a cycle where imem_req_valid && imem_req_ready;
    // a buffered instruction transfers on a cycle where instr_valid && instr_ready.
    // imem_resp_valid is a one-cycle pulse with no back-pressure.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    logic [63:0] r_pc;
    logic [63:0] r_inflight_pc;
    logic [31:0] r_buf_data [FIFO_DEPTH];
    logic [63:0] r_buf_pc   [FIFO_DEPTH];
    logic        r_head;
    logic        r_tail;
    logic [1:0]  r_count;

    logic w_req_fire;
    logic w_push;
    logic w_pop;
    logic w_has_space;
    logic w_unused_ok;

    // Only IDLE can issue, so nothing is outstanding when the space check is made;
    // a request is issued only if its response is guaranteed a slot.
    assign w_has_space = (r_count < 2'(FIFO_DEPTH));
    assign imem_req_valid = !rst && (r_state == S_IDLE) && w_has_space
                            && !redirect_valid && !halt;
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;

    // A redirect in the same cycle discards both the incoming word and the pop.
    assign w_push = (r_state == S_WAIT) && imem_resp_valid && !redirect_valid;
    assign w_pop  = instr_valid && instr_ready && !redirect_valid;

    assign instr_valid = !rst && (r_count != 2'd0);
    assign instr_o     = instr_valid ? r_buf_data[r_head] : 32'd0;
    assign pc_o        = instr_valid ? r_buf_pc[r_head]   : 64'd0;
    assign dbg_state   = r_state;

    // Low redirect bits are forced to zero and never used.
    assign w_unused_ok = &{1'b0, redirect_pc[1:0]};

    // Fetch PC, fetch FSM and buffer pointers/occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_state       <= S_IDLE;
            r_inflight_pc <= 64'd0;
            r_head        <= 1'b0;
            r_tail        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            if (redirect_valid) begin
                r_pc <= {redirect_pc[63:2], 2'b00};
            end else if (w_req_fire) begin
                r_pc <= r_pc + 64'd4;
            end

            case (r_state)
                S_IDLE: begin
                    // Responses seen in IDLE are stale or zero-latency and are ignored.
                    if (w_req_fire) begin
                        r_state       <= S_WAIT;
                        r_inflight_pc <= r_pc;
                    end
                end
                S_WAIT: begin
                    if (imem_resp_valid) begin
                        r_state <= S_IDLE;
                    end else if (redirect_valid) begin
                        r_state <= S_DROP;
                    end
                end
                S_DROP: begin
                    // The response being waited for ends DROP even if another
                    // redirect lands in the same cycle; nothing else is in flight.
                    if (imem_resp_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (redirect_valid) begin
                r_head  <= 1'b0;
                r_tail  <= 1'b0;
                r_count <= 2'd0;
            end else begin
                if (w_push) begin
                    r_tail <= r_tail + 1'b1;
                end
                if (w_pop) begin
                    r_head <= r_head + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Buffer storage; contents are only observed through occupancy, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_data[r_tail] <= imem_resp_data;
            r_buf_pc[r_tail]   <= r_inflight_pc;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_ifu.sv
// Directed bench for the fetch unit: reset, steady fetch, full buffer,
// redirect drop, redirect with simultaneous push/pop, halt, reset mid-request.
module tb_ysyx_220053_ifu;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  ysyx_220053_ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .dbg_state       (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change on the falling edge; outputs are checked 1 time unit later
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'd0;
    instr_ready     = 1'b0;
    redirect_valid  = 1'b0;
    redirect_pc     = 64'd0;
    halt            = 1'b0;

    // reset state
    next_cycle(); next_cycle(); settle();
    chk("rst_req_valid",   64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid),    64'd0);
    chk("rst_instr_o",     64'(instr_o),        64'd0);
    chk("rst_pc_o",        pc_o,                64'd0);
    chk("rst_state",       64'(dbg_state),      64'd0);

    // first request in the first cycle out of reset
    next_cycle(); rst = 1'b0; settle();
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr",  imem_req_addr,       64'h8000_0000);

    // 1-cycle response
    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0093; settle();
    chk("wait_req_valid",  64'(imem_req_valid), 64'd0);
    chk("wait_instr_valid", 64'(instr_valid),   64'd0);

    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("w0_instr_valid",  64'(instr_valid),    64'd1);
    chk("w0_instr_o",      64'(instr_o),        64'h0010_0093);
    chk("w0_pc_o",         pc_o,                64'h8000_0000);
    chk("second_req_valid", 64'(imem_req_valid), 64'd1);
    chk("second_req_addr", imem_req_addr,       64'h8000_0004);

    // decoder stalled: second word fills the buffer, then fetching stops
    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0020_0113; settle();
    chk("w1_wait_req_valid", 64'(imem_req_valid), 64'd0);

    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("full_req_valid",  64'(imem_req_valid), 64'd0);
    chk("full_head",       64'(instr_o),        64'h0010_0093);

    next_cycle(); instr_ready = 1'b1; settle();
    chk("full_req_valid2", 64'(imem_req_valid), 64'd0);
    chk("full_state",      64'(dbg_state),      64'd0);
    chk("pop0_instr_o",    64'(instr_o),        64'h0010_0093);

    // second word at head; space opens so the third request goes out
    next_cycle(); settle();
    chk("pop1_instr_o",    64'(instr_o),        64'h0020_0113);
    chk("pop1_pc_o",       pc_o,                64'h8000_0004);
    chk("third_req_valid", 64'(imem_req_valid), 64'd1);
    chk("third_req_addr",  imem_req_addr,       64'h8000_0008);

    // redirect while waiting; its response comes 3 cycles later and is dropped
    next_cycle(); instr_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h8000_0103; settle();
    chk("redir_instr_valid", 64'(instr_valid),  64'd0);
    chk("redir_req_valid", 64'(imem_req_valid), 64'd0);

    next_cycle(); redirect_valid = 1'b0; settle();
    chk("drop_state",      64'(dbg_state),      64'd2);
    chk("drop_req_valid",  64'(imem_req_valid), 64'd0);

    next_cycle(); settle();
    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'hdead_beef; settle();
    chk("drop_resp_req_valid", 64'(imem_req_valid), 64'd0);

    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("dropped_instr_valid", 64'(instr_valid), 64'd0);
    chk("redir_req_valid2", 64'(imem_req_valid), 64'd1);
    chk("redir_req_addr",  imem_req_addr,       64'h8000_0100);

    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0030_0193; settle();
    chk("redir_wait_instr_valid", 64'(instr_valid), 64'd0);

    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("redir_instr_o",   64'(instr_o),        64'h0030_0193);
    chk("redir_pc_o",      pc_o,                64'h8000_0100);
    chk("next_req_addr",   imem_req_addr,       64'h8000_0104);

    // redirect together with a response and a pop: everything is flushed
    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0040_0213;
    instr_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'h8000_0200; settle();
    chk("flush_pre_valid", 64'(instr_valid),    64'd1);

    next_cycle(); imem_resp_valid = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b0; settle();
    chk("flush_instr_valid", 64'(instr_valid),  64'd0);
    chk("flush_state",     64'(dbg_state),      64'd0);
    chk("flush_req_addr",  imem_req_addr,       64'h8000_0200);

    // halt while waiting: pending response still buffered, no new requests
    next_cycle(); halt = 1'b1; settle();
    chk("halt_wait_req_valid", 64'(imem_req_valid), 64'd0);

    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0010_0073; settle();
    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("ebreak_valid",    64'(instr_valid),    64'd1);
    chk("ebreak_instr_o",  64'(instr_o),        64'h0010_0073);
    chk("ebreak_pc_o",     pc_o,                64'h8000_0200);
    chk("halt_req_valid",  64'(imem_req_valid), 64'd0);

    next_cycle(); instr_ready = 1'b1; settle();
    chk("halt_req_valid2", 64'(imem_req_valid), 64'd0);

    next_cycle(); instr_ready = 1'b0; settle();
    chk("halt_empty",      64'(instr_valid),    64'd0);
    chk("halt_req_valid3", 64'(imem_req_valid), 64'd0);

    // release halt, issue, then reset mid-request with a stale response after
    next_cycle(); halt = 1'b0; settle();
    chk("unhalt_req_addr", imem_req_addr,       64'h8000_0204);

    next_cycle(); rst = 1'b1; settle();
    chk("rst2_req_valid",  64'(imem_req_valid), 64'd0);
    chk("rst2_instr_valid", 64'(instr_valid),   64'd0);

    next_cycle(); rst = 1'b0; imem_resp_valid = 1'b1; imem_resp_data = 32'hbadb_ad00; settle();
    chk("rst2_req_valid2", 64'(imem_req_valid), 64'd1);
    chk("rst2_req_addr",   imem_req_addr,       64'h8000_0000);
    chk("rst2_state",      64'(dbg_state),      64'd0);

    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("stale_instr_valid", 64'(instr_valid),  64'd0);
    chk("rst2_wait_state", 64'(dbg_state),      64'd1);

    next_cycle(); imem_resp_valid = 1'b1; imem_resp_data = 32'h0050_0293; settle();
    next_cycle(); imem_resp_valid = 1'b0; settle();
    chk("rst2_instr_o",    64'(instr_o),        64'h0050_0293);
    chk("rst2_pc_o",       pc_o,                64'h8000_0000);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_220053_ifu.md
YSYX_220053_IFU -- requirements
Module: ysyx_220053_IFU

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0000_0000_8000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FIFO_DEPTH, default 2, meaning the instruction buffer entries (fixed at 2 in this revision).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts the request.
REQ-007 SHALL have port imem_req_addr  output  64  fetch address, bits [1:0] always 0.
REQ-008 SHALL have port imem_resp_valid  input  1  fetch data returned, one cycle pulse.
REQ-009 SHALL have port imem_resp_data  input  32  returned instruction word.
REQ-010 SHALL have port instr_valid  output  1  buffer head valid toward decoder.
REQ-011 SHALL have port instr_ready  input  1  decoder consumes the head.
REQ-012 SHALL have port instr_o  output  32  head instruction word, fed to decoder instr_i.
REQ-013 SHALL have port pc_o  output  64  PC of the head instruction.
REQ-014 SHALL have port redirect_valid  input  1  branch/jump/trap redirect.
REQ-015 SHALL have port redirect_pc  input  64  redirect target; bits [1:0] ignored (forced 0).
REQ-016 SHALL have port halt  input  1  level; stops new fetch requests (asserted after ebreak trap).

Function
REQ-017 SHALL keep a fetch PC register; it advances by 4 on each accepted request (imem_req_valid && imem_req_ready).
REQ-018 SHALL allow at most one outstanding request; FSM states IDLE, WAIT, DROP.
REQ-019 SHALL drive imem_req_valid = (state==IDLE) && (occupancy + 0 < 2) && !redirect_valid && !halt, combinationally; imem_req_addr = fetch PC.
REQ-020 IDLE -> WAIT on accepted request; the accepted address SHALL be latched as the in-flight PC.
REQ-021 WAIT -> IDLE on imem_resp_valid; {in-flight PC, imem_resp_data} SHALL be written to the buffer tail that edge.
REQ-022 Space check SHALL reserve a slot for the in-flight request so the buffer never overflows (occupancy + outstanding <= 2).
REQ-023 instr_valid SHALL equal buffer non-empty; head SHALL pop when instr_valid && instr_ready.
REQ-024 Simultaneous push and pop SHALL both take effect; occupancy unchanged; order preserved (FIFO, pointers wrap mod 2).
REQ-025 Response latency from memory is arbitrary (>=1 cycle); zero-latency responses in the request cycle SHALL NOT be accepted.
REQ-026 redirect_valid SHALL have highest priority: fetch PC <= {redirect_pc[63:2],2'b00}; buffer flushed (occupancy 0); any same-cycle pop or push discarded.
REQ-027 Redirect in WAIT without same-cycle imem_resp_valid SHALL move to DROP; with same-cycle response SHALL move to IDLE, data discarded.
REQ-028 DROP SHALL discard the next imem_resp_valid and then go to IDLE; a further redirect in DROP SHALL update fetch PC and remain in DROP.
REQ-029 Redirect in IDLE SHALL stay in IDLE; the first request to the new target SHALL be issued the following cycle.
REQ-030 halt SHALL not cancel an outstanding request; its response SHALL still be buffered; instr_valid behaviour unchanged.
REQ-031 With imem_req_ready=1 and 1-cycle response latency and instr_ready=1, sustained throughput SHALL be one instruction per 2 cycles.

Reset
REQ-032 While rst=1: fetch PC = RESET_PC, state IDLE, occupancy 0, imem_req_valid 0, instr_valid 0, instr_o 0, pc_o 0.
REQ-033 rst asserted mid-request (WAIT or DROP) SHALL return to IDLE; a response arriving during or after reset with no request issued since SHALL be ignored.
REQ-034 First request after rst deasserts SHALL be issued in the first cycle with rst=0, address RESET_PC.

Verification
REQ-035 Reset release, ready=1, 1-cycle latency, data 0x00100093 -> req addr 0x80000000, instr_o=0x00100093, pc_o=0x80000000, next req 0x80000004.
REQ-036 instr_ready=0, memory always ready -> exactly 2 requests issued (0x80000000, 0x80000004), then imem_req_valid stays 0; instr_valid 1 holding first word.
REQ-037 Redirect to 0x80000103 while in WAIT, response 3 cycles later -> response dropped, next req addr 0x80000100, instr_valid 0 until its response.
REQ-038 Redirect in same cycle as imem_resp_valid and pop -> buffer empty next cycle, state IDLE, no stale instruction delivered.
REQ-039 halt=1 while WAIT -> pending response buffered, no further imem_req_valid; ebreak word 0x00100073 delivered with correct pc_o.
REQ-040 rst pulsed in WAIT, stale response arrives next cycle -> response ignored, req to 0x80000000 reissued, instr_valid 0 until new response.
